// File: rtl/tx_frame_ctrl_if.sv
// Wishbone-style sample stream: one 32-bit {I,Q} sample per acknowledged strobe.
// The same bundle is used on the upstream (symbol pipeline) and the
// downstream (transmit output stage) side of the frame sequencer.
interface tx_frame_ctrl_if;
  logic [31:0] dat;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;

  modport master (output dat, cyc, stb, we, input ack);
  modport slave  (input dat, cyc, stb, we, output ack);
endinterface

// File: rtl/tx_frame_ctrl.sv
// Transmit frame sequencer. Forwards samples from the symbol pipeline to the
// output stage without added latency. Counts samples per symbol and symbols
// per frame. Drops downstream CYC after the last symbol plus a drain window,
// so the output stage re-inserts its preamble on the next frame. Holds off
// upstream for an inter-frame gap.
module tx_frame_ctrl #(
  parameter int unsigned SYM_LEN   = 320,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned GAP_CYC   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            nsym_i,
  tx_frame_ctrl_if.slave        up,
  tx_frame_ctrl_if.master       dn,
  output logic                  frm_busy_o,
  output logic                  frm_done_o,
  output logic                  frm_err_o,
  output logic [7:0]            sym_cnt_o
);

  localparam int unsigned SW   = $clog2(SYM_LEN);
  localparam int unsigned TMAX = (DRAIN_CYC > GAP_CYC) ? DRAIN_CYC : GAP_CYC;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [SW-1:0] SAMP_LAST  = SW'(SYM_LEN - 1);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_DRAIN,
    ST_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [7:0]    sym_q, sym_d;
  logic [7:0]    nlast_q, nlast_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          ena;
  logic          acc;
  logic          up_ack;
  logic          dn_cyc;
  logic          dn_stb;
  logic          dn_we;
  logic [31:0]   dn_dat;

  assign ena = up.cyc & up.stb & up.we;
  assign acc = dn_stb & dn.ack;

  // State, counters, timer and status pulses; reset returns everything to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      samp_q  <= '0;
      sym_q   <= '0;
      nlast_q <= '0;
      tmr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      sym_q   <= sym_d;
      nlast_q <= nlast_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic plus the combinational bus pass-through while in FRAME.
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    sym_d   = sym_q;
    nlast_d = nlast_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    up_ack  = 1'b0;
    dn_cyc  = 1'b0;
    dn_stb  = 1'b0;
    dn_we   = 1'b0;
    dn_dat  = '0;

    case (state_q)
      ST_IDLE: begin
        if (ena) begin
          state_d = ST_FRAME;
          // A zero symbol count is treated as a single symbol.
          nlast_d = (nsym_i == 8'd0) ? 8'd0 : (nsym_i - 8'd1);
          samp_d  = '0;
          sym_d   = '0;
        end
      end

      ST_FRAME: begin
        dn_cyc = 1'b1;
        dn_stb = ena;
        dn_we  = ena;
        dn_dat = up.dat;
        up_ack = dn.ack & ena;
        // A transfer needs CYC_I high, so last-sample always beats abort.
        if (acc) begin
          if (samp_q == SAMP_LAST) begin
            samp_d = '0;
            sym_d  = sym_q + 8'd1;
            if (sym_q == nlast_q) begin
              state_d = ST_DRAIN;
              tmr_d   = '0;
              done_d  = 1'b1;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end else if (!up.cyc) begin
          state_d = ST_GAP;
          tmr_d   = '0;
          err_d   = 1'b1;
          samp_d  = '0;
          sym_d   = '0;
        end
      end

      ST_DRAIN: begin
        dn_cyc = 1'b1;
        if (tmr_q == DRAIN_LAST) begin
          state_d = ST_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign up.ack     = up_ack;
  assign dn.cyc     = dn_cyc;
  assign dn.stb     = dn_stb;
  assign dn.we      = dn_we;
  assign dn.dat     = dn_dat;
  assign frm_busy_o = (state_q == ST_FRAME) || (state_q == ST_DRAIN);
  assign frm_done_o = done_q;
  assign frm_err_o  = err_q;
  assign sym_cnt_o  = sym_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed bench for tx_frame_ctrl: upstream source with continuous strobe,
// downstream sink with selectable acknowledge pattern, per-frame statistics.
module tb_tx_frame_ctrl;
  localparam int SYM_LEN   = 320;
  localparam int DRAIN_CYC = 4;
  localparam int GAP_CYC   = 64;
  localparam int PRE       = 576;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] nsym = 8'd1;
  logic       busy, done, err;
  logic [7:0] symc;

  tx_frame_ctrl_if up_if ();
  tx_frame_ctrl_if dn_if ();

  tx_frame_ctrl #(
    .SYM_LEN  (SYM_LEN),
    .DRAIN_CYC(DRAIN_CYC),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .nsym_i    (nsym),
    .up        (up_if),
    .dn        (dn_if),
    .frm_busy_o(busy),
    .frm_done_o(done),
    .frm_err_o (err),
    .sym_cnt_o (symc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // downstream ack mode: 0 tied high, 1 preamble stall, 2 random
  int mode = 0;
  int since_rise = 0;
  int tx_idx = 0, rx_idx = 0;
  int acks, done_cnt, err_cnt, hi_after, data_err, stall_viol, ack_err;
  int drop_at = -1;
  logic dropped = 1'b0;
  int late_at = -1;
  logic [7:0] late_val = 8'd0;
  int sym_rec [0:1023];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {v[15:0] * 16'd3 + 16'd1, ~v[15:0]};
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later.
  task automatic step();
    logic acc;
    up_if.cyc = 1'b1;
    if (drop_at >= 0 && !dropped && acks == drop_at) begin
      up_if.cyc = 1'b0;
      dropped   = 1'b1;
    end
    if (late_at >= 0 && acks == late_at) nsym = late_val;
    case (mode)
      1:       dn_if.ack = dn_if.cyc && (since_rise >= PRE);
      2:       dn_if.ack = 1'($urandom_range(0, 1));
      default: dn_if.ack = 1'b1;
    endcase
    up_if.dat = pat(tx_idx);
    #1;
    if (acks < 1024 && sym_rec[acks] < 0) sym_rec[acks] = int'(symc);
    acc = dn_if.stb & dn_if.ack;
    if (mode == 1 && since_rise < PRE && up_if.ack) stall_viol++;
    if (acc) begin
      if (dn_if.dat !== pat(rx_idx) || dn_if.we !== 1'b1) data_err++;
      rx_idx++;
      acks++;
      hi_after = 0;
    end else if (dn_if.cyc) begin
      hi_after++;
    end
    if (up_if.ack) tx_idx++;
    if (up_if.ack !== acc) ack_err++;
    done_cnt += int'(done);
    err_cnt  += int'(err);
    since_rise = dn_if.cyc ? since_rise + 1 : 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tx_idx = 0;
    rx_idx = 0;
    rst = 1'b0;
  endtask

  // Runs one frame from CYC_O rise to the next rise (gap measured with ena held high).
  task automatic run_frame(input string tag, input int e_acks, input int e_done, input int e_err,
                           input int e_hi, input int e_sym, input int e_len, input int drop);
    int n, len, low, sym_end;
    acks = 0; done_cnt = 0; err_cnt = 0; hi_after = 0;
    data_err = 0; stall_viol = 0; ack_err = 0;
    drop_at = drop; dropped = 1'b0;
    for (int i = 0; i < 1024; i++) sym_rec[i] = -1;
    n = 0;
    while (!dn_if.cyc && n < 200) begin step(); n++; end
    check({tag, "_rise"}, 32'(dn_if.cyc), 1);
    len = 0;
    while (dn_if.cyc && len < 8000) begin step(); len++; end
    check({tag, "_fall"}, 32'(dn_if.cyc), 0);
    sym_end = int'(symc);
    low = 0;
    while (!dn_if.cyc && low < 300) begin step(); low++; end
    $display("frame %s: acks=%0d len=%0d low=%0d sym=%0d done=%0d err=%0d",
             tag, acks, len, low, sym_end, done_cnt, err_cnt);
    check({tag, "_acks"}, acks, e_acks);
    check({tag, "_done"}, done_cnt, e_done);
    check({tag, "_err"}, err_cnt, e_err);
    check({tag, "_drain"}, hi_after, e_hi);
    check({tag, "_sym"}, sym_end, e_sym);
    check({tag, "_gap"}, low, GAP_CYC + 1);
    check({tag, "_data"}, data_err, 0);
    check({tag, "_ackpath"}, ack_err, 0);
    if (e_len >= 0) check({tag, "_len"}, len, e_len);
    if (mode == 1) check({tag, "_stall"}, stall_viol, 0);
  endtask

  initial begin
    int n;
    up_if.cyc = 1'b0; up_if.stb = 1'b0; up_if.we = 1'b0; up_if.dat = '0;
    dn_if.ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cyc", 32'(dn_if.cyc), 0);
    check("rst_stb", 32'(dn_if.stb), 0);
    check("rst_ack", 32'(up_if.ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done_err", {30'd0, done, err}, 0);
    check("rst_sym", 32'(symc), 0);
    up_if.stb = 1'b1; up_if.we = 1'b1; up_if.cyc = 1'b1;

    // Two symbols, acknowledge tied high
    do_reset();
    nsym = 8'd2; mode = 0;
    run_frame("t1", 640, 1, 0, DRAIN_CYC, 2, 640 + DRAIN_CYC, -1);
    check("t1_sym319", sym_rec[319], 0);
    check("t1_sym320", sym_rec[320], 1);
    check("t1_sym639", sym_rec[639], 1);
    check("t1_sym640", sym_rec[640], 2);

    // Preamble stall of 576 cycles, one symbol
    do_reset();
    nsym = 8'd1; mode = 1;
    run_frame("t2", 320, 1, 0, DRAIN_CYC, 1, PRE + 320 + DRAIN_CYC, -1);

    // NSYM 0 means one symbol; change to 5 mid-frame is ignored
    do_reset();
    nsym = 8'd0; mode = 0; late_at = 50; late_val = 8'd5;
    run_frame("t3", 320, 1, 0, DRAIN_CYC, 1, 320 + DRAIN_CYC, -1);
    late_at = -1;

    // Upstream CYC lost after 100 samples
    do_reset();
    nsym = 8'd2; mode = 0;
    run_frame("t4", 100, 0, 1, 1, 0, 101, 100);
    drop_at = -1;

    // Asynchronous reset between clock edges mid-symbol
    do_reset();
    nsym = 8'd1; mode = 0; acks = 0;
    n = 0;
    while (acks < 150 && n < 500) begin step(); n++; end
    check("t5_pre_cyc", 32'(dn_if.cyc), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_cyc", 32'(dn_if.cyc), 0);
    check("t5_async_stb", 32'(dn_if.stb), 0);
    check("t5_async_ack", 32'(up_if.ack), 0);
    check("t5_async_busy", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; tx_idx = 0; rx_idx = 0;
    run_frame("t5", 320, 1, 0, DRAIN_CYC, 1, 320 + DRAIN_CYC, -1);

    // Random acknowledge, two back-to-back 3-symbol frames
    do_reset();
    nsym = 8'd3; mode = 2;
    run_frame("t6a", 960, 1, 0, DRAIN_CYC, 3, -1, -1);
    run_frame("t6b", 960, 1, 0, DRAIN_CYC, 3, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
